// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : uart_pkg                                                    |
// | Description: Definitions shared by the UART receiver and the downstream  |
// |              $xx / #xx command parser: receiver FSM state encoding,      |
// |              default clock / baud constants and ASCII command bytes.     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package uart_pkg;

  // Default system clock and line rate.
  localparam int DEF_CLK_FREQ = 25_000_000;
  localparam int DEF_BAUD     = 115_200;

  // ASCII command leaders understood by the command parser.
  localparam logic [7:0] CMD_TX_COUNT = 8'h24;  // '$'
  localparam logic [7:0] CMD_REG_DATA = 8'h23;  // '#'

  // Receiver FSM states. PARITY is only reachable in the parity build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : uart_rx_sync                                                |
// | Description: Two-flop synchroniser for the raw serial line followed by a |
// |              third flop for falling-edge detection. All flops reset to   |
// |              the idle-high level so reset release never fakes an edge.   |
// | Ports      : clk      - system clock                                     |
// |              rst      - asynchronous reset, active low                   |
// |              uart_rxd - raw serial input, asynchronous to clk            |
// |              rxd_s    - synchronised line level                          |
// |              rxd_fall - one-cycle pulse on a synchronised 1->0 edge      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic uart_rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= uart_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rxd_s    = r_sync;
  assign rxd_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : uart_rx                                                     |
// | Description: 8N1 asynchronous serial receiver. Emits one single-cycle    |
// |              from_uart_valid strobe per good frame; a bad stop bit       |
// |              gives a single-cycle frame_err instead. No buffering.       |
// |              Define UART_RX_PARITY_EN to add an even-parity bit between  |
// |              the data bits and the stop bit (8E1).                       |
// | Ports      : clk             - system clock, rising edge                 |
// |              rst             - asynchronous reset, active low            |
// |              uart_rxd        - raw serial line, idle high                |
// |              from_uart_valid - one-cycle good-byte strobe                |
// |              from_uart_data  - last good byte                            |
// |              frame_err       - one-cycle framing / parity error strobe   |
// |              busy            - FSM is not in IDLE                        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       from_uart_valid,
  output logic [7:0] from_uart_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

  // Mid-bit sampling needs a meaningful half period.
  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
      $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Line synchroniser and start-edge detector
  // ---------------------------------------------------------------------
  logic w_rxd_s;
  logic w_rxd_fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rxd_s    (w_rxd_s),
    .rxd_fall (w_rxd_fall)
  );

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  uart_state_t        r_state;
  uart_state_t        w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_nxt;
  logic [7:0]         r_shreg;
  logic [7:0]         w_shreg_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic [7:0]         r_data;
  logic [7:0]         w_data_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_frame_ok;

  wire w_tick_half = (r_cnt == c_HALF_M1);
  wire w_tick_full = (r_cnt == c_FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic w_par_err_nxt;

  // Stop must be high and the received parity must have been even.
  assign w_frame_ok = w_rxd_s & ~r_par_err;
`else
  assign w_frame_ok = w_rxd_s;
`endif

  // State register (process 1 of 3)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'h00;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_valid   <= w_valid_nxt;
      r_data    <= w_data_nxt;
      r_err     <= w_err_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_err_nxt;
`endif
    end
  end

  // Next-state logic (process 2 of 3). The counter is cleared at every
  // sample point and held at zero in IDLE, so it never wraps.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
`ifdef UART_RX_PARITY_EN
    w_par_err_nxt = r_par_err;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rxd_fall) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick_half) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = 3'd0;
          // A line already back high at mid-start was only a glitch.
          w_state_nxt   = w_rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick_full) begin
          w_cnt_nxt     = '0;
          // LSB arrives first, so shift in from the top.
          w_shreg_nxt   = {w_rxd_s, r_shreg[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick_full) begin
          w_cnt_nxt     = '0;
          // Even parity: data plus parity bit must hold an even count of ones.
          w_par_err_nxt = ^{r_shreg, w_rxd_s};
          w_state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tick_full) begin
          w_cnt_nxt   = '0;
          // Leave at mid-stop so a start edge right after it is caught.
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic (process 3 of 3). Valid and error are mutually exclusive
  // because they come from the two arms of one decision.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_data_nxt  = r_data;
    if (r_state == STOP && w_tick_full) begin
      if (w_frame_ok) begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = r_shreg;
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  assign from_uart_valid = r_valid;
  assign from_uart_data  = r_data;
  assign frame_err       = r_err;
  assign busy            = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_uart_rx                                                  |
// | Description: Directed self-checking bench for uart_rx. Frames are        |
// |              driven bit by bit at 217 clocks per bit; a monitor logs     |
// |              every strobe with its cycle number for later comparison.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 217;
  // Strobe cycle relative to the cycle the pin is driven low: two cycles to
  // the detected edge, then the fixed frame latency after it.
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + 2279;
`else
  localparam int LAT = 2 + 2062;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       from_uart_valid;
  logic [7:0] from_uart_data;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (25_000_000),
    .BAUD     (115_200)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rxd        (uart_rxd),
    .from_uart_valid (from_uart_valid),
    .from_uart_data  (from_uart_data),
    .frame_err       (frame_err),
    .busy            (busy)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         e_cyc[$];
  int         busy_cnt = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (from_uart_valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(from_uart_data);
    end
    if (frame_err) e_cyc.push_back(cyc);
    if (from_uart_valid && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    v_cyc.delete();
    v_dat.delete();
    e_cyc.delete();
    busy_cnt = 0;
  endtask

  function automatic int vc(input int i);
    return (v_cyc.size() > i) ? v_cyc[i] : -1;
  endfunction

  function automatic logic [7:0] vd(input int i);
    return (v_dat.size() > i) ? v_dat[i] : 8'hxx;
  endfunction

  function automatic int ec(input int i);
    return (e_cyc.size() > i) ? e_cyc[i] : -1;
  endfunction

  // Drives one whole frame; must be entered just after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic par_flip, output int t_start);
    uart_rxd = 1'b0;
    t_start  = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ par_flip;
    tick(CPB);
`endif
    uart_rxd = stop_v;
    tick(CPB);
  endtask

  initial begin
    int t0, t1, t2;
    logic [7:0] b;

    rst      = 1'b0;
    uart_rxd = 1'b1;
    tick(5);
    check("rst_valid", from_uart_valid, 1'b0);
    check("rst_data",  from_uart_data,  8'h00);
    check("rst_err",   frame_err,       1'b0);
    check("rst_busy",  busy,            1'b0);
    rst = 1'b1;
    tick(20);

    // Single good frame '$'
    clear_mon();
    send_frame(CMD_TX_COUNT, 1'b1, 1'b0, t0);
    tick(300);
    check("one_count", v_cyc.size(), 1);
    check("one_cycle", vc(0), t0 + LAT);
    check("one_data",  vd(0), 8'h24);
    check("one_err",   e_cyc.size(), 0);
    check("one_hold",  from_uart_data, 8'h24);
    check("one_idle",  busy, 1'b0);

    // Back-to-back frames, no idle gap
    clear_mon();
    send_frame(CMD_REG_DATA, 1'b1, 1'b0, t0);
    send_frame(8'h35, 1'b1, 1'b0, t1);
    send_frame(8'h37, 1'b1, 1'b0, t2);
    tick(300);
    check("b2b_count", v_cyc.size(), 3);
    check("b2b_d0",    vd(0), 8'h23);
    check("b2b_d1",    vd(1), 8'h35);
    check("b2b_d2",    vd(2), 8'h37);
    check("b2b_c0",    vc(0), t0 + LAT);
    check("b2b_c1",    vc(1), t1 + LAT);
    check("b2b_c2",    vc(2), t2 + LAT);
    check("b2b_err",   e_cyc.size(), 0);

    // 50-clock low glitch on an idle line
    clear_mon();
    uart_rxd = 1'b0;
    tick(50);
    uart_rxd = 1'b1;
    tick(400);
    check("glitch_valid", v_cyc.size(), 0);
    check("glitch_err",   e_cyc.size(), 0);
    check("glitch_busy",  busy_cnt, 108);

    // Bad stop bit, line then stuck low
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0, t0);
    busy_cnt = 0;
    tick(3000);
    check("stop_err_count", e_cyc.size(), 1);
    check("stop_err_cycle", ec(0), t0 + LAT);
    check("stop_valid",     v_cyc.size(), 0);
    check("stop_data_kept", from_uart_data, 8'h37);
    check("stop_low_busy",  busy_cnt, 0);
    uart_rxd = 1'b1;
    tick(400);
    check("stop_rise_busy", busy_cnt, 0);

    // Reset during data bit 4 of 0x9A, then a fresh frame
    clear_mon();
    b = 8'h9A;
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = b[4];
    tick(100);
    rst = 1'b0;
    tick(2);
    check("mid_rst_valid", from_uart_valid, 1'b0);
    check("mid_rst_data",  from_uart_data,  8'h00);
    check("mid_rst_err",   frame_err,       1'b0);
    check("mid_rst_busy",  busy,            1'b0);
    tick(CPB - 102);
    for (int i = 5; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = 1'b1;
    tick(CPB);
    check("mid_rst_late_data", from_uart_data, 8'h00);
    check("mid_rst_late_busy", busy, 1'b0);
    rst = 1'b1;
    tick(400);
    send_frame(8'h11, 1'b1, 1'b0, t0);
    tick(300);
    check("post_rst_count", v_cyc.size(), 1);
    check("post_rst_data",  vd(0), 8'h11);
    check("post_rst_cycle", vc(0), t0 + LAT);
    check("post_rst_err",   e_cyc.size(), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, t0);
    tick(300);
    check("par_ok_count", v_cyc.size(), 1);
    check("par_ok_cycle", vc(0), t0 + LAT);
    check("par_ok_data",  vd(0), 8'h07);
    check("par_ok_err",   e_cyc.size(), 0);

    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, t0);
    tick(300);
    check("par_bad_valid", v_cyc.size(), 0);
    check("par_bad_err",   e_cyc.size(), 1);
    check("par_bad_cycle", ec(0), t0 + LAT);
    check("par_bad_data",  from_uart_data, 8'h07);
`endif

    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
